// File: rtl/prm_pkg.sv
// Shared types, field layout and saturating field arithmetic for the PRM edge sweep.
package prm_pkg;

    localparam int JOINT_W = 5;
    localparam int STEP_W  = 6;
    localparam int CODE_W  = 15;
    localparam int NJOINT  = 3;

    // Field positions inside the 15-bit code and the 18-bit step word.
    localparam int J0_LSB = 0;
    localparam int J1_LSB = 5;
    localparam int J2_LSB = 10;
    localparam int S0_LSB = 0;
    localparam int S1_LSB = 6;
    localparam int S2_LSB = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // field + signed step, saturated to [0, 31]. The 7-bit signed sum covers
    // the full range -32..62, so bit 6 flags negative and bit 5 flags > 31.
    function automatic logic [JOINT_W-1:0] clamp_field(input logic [JOINT_W-1:0] f,
                                                       input logic [STEP_W-1:0]  s);
        logic signed [JOINT_W+1:0] sum;
        sum = $signed({2'b00, f}) + $signed({s[STEP_W-1], s});
        if (sum[JOINT_W+1])
            clamp_field = '0;
        else if (sum[JOINT_W])
            clamp_field = '1;
        else
            clamp_field = sum[JOINT_W-1:0];
    endfunction

endpackage

// File: rtl/prm_code_step.sv
// Combinational three-field saturating adder: next joint code from current code and step.
module prm_code_step
    import prm_pkg::*;
(
    input  logic [CODE_W-1:0]        code,
    input  logic [NJOINT*STEP_W-1:0] step,
    output logic [CODE_W-1:0]        code_nxt
);

    // Each joint field advances independently and saturates; no carry between fields.
    always_comb begin
        code_nxt = '0;
        for (int j = 0; j < NJOINT; j++) begin
            code_nxt[j*JOINT_W +: JOINT_W] = clamp_field(code[j*JOINT_W +: JOINT_W],
                                                         step[j*STEP_W +: STEP_W]);
        end
    end

endmodule

// File: rtl/prm_edge_sweep.sv
// Edge sweep sequencer: walks one roadmap edge sample by sample through the
// checker bank and returns a single collision verdict with early exit.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. req_ready is high only in IDLE; res_valid is high only in DONE and
// the result fields hold steady until res_ready is seen with res_valid.
module prm_edge_sweep
    import prm_pkg::*;
#(
    parameter int NCHK  = 8,
    parameter int CNT_W = 8,
    parameter int CHK_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CODE_W-1:0]        req_start,
    input  logic [NJOINT*STEP_W-1:0] req_step,
    input  logic [CNT_W-1:0]         req_steps,
    output logic [CODE_W-1:0]        chk_code,
    input  logic [NCHK-1:0]          chk_mask,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_hit,
    output logic [CNT_W-1:0]         res_idx,
    output logic [CHK_W-1:0]         res_chk,
    output logic [CODE_W-1:0]        res_code,
    output state_e                   dbg_state
);

    state_e                    state_q, state_d;
    logic [CODE_W-1:0]         code_q;
    logic [NJOINT*STEP_W-1:0]  step_q;
    logic [CNT_W-1:0]          rem_q;
    logic [CNT_W-1:0]          idx_q;
    logic                      pend_q;
    logic [NCHK-1:0]           mask_q;
    logic [CODE_W-1:0]         mcode_q;
    logic [CNT_W-1:0]          midx_q;
    logic [CODE_W-1:0]         code_nxt;
    logic                      hit;

    function automatic logic [CHK_W-1:0] lowest_set(input logic [NCHK-1:0] m);
        lowest_set = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CHK_W'(i);
        end
    endfunction

    prm_code_step u_step (
        .code     (code_q),
        .step     (step_q),
        .code_nxt (code_nxt)
    );

    // The previous cycle's registered mask is evaluated while the next sample is on the bus.
    assign hit = pend_q && (|mask_q) && (state_q == SWEEP || state_q == DRAIN);

    // code_q is frozen on the last sample, so the checker bus holds it through DRAIN.
    assign chk_code  = code_q;
    assign dbg_state = state_q;

    // Next-state selection; a hit outranks the move into DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = SWEEP;
            SWEEP:   if (hit) state_d = DONE;
                     else if (rem_q == '0) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus the registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= (state_d == IDLE);
            res_valid <= (state_d == DONE);
        end
    end

    // Sweep datapath: load the edge, step samples, capture masks, latch the verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= '0;
            step_q   <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            mask_q   <= '0;
            mcode_q  <= '0;
            midx_q   <= '0;
            res_hit  <= 1'b0;
            res_idx  <= '0;
            res_chk  <= '0;
            res_code <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        code_q <= req_start;
                        step_q <= req_step;
                        rem_q  <= req_steps;
                        idx_q  <= '0;
                        pend_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (hit) begin
                        res_hit  <= 1'b1;
                        res_idx  <= midx_q;
                        res_chk  <= lowest_set(mask_q);
                        res_code <= mcode_q;
                    end else begin
                        mask_q  <= chk_mask;
                        mcode_q <= code_q;
                        midx_q  <= idx_q;
                        pend_q  <= 1'b1;
                        idx_q   <= idx_q + 1'b1;
                        rem_q   <= rem_q - 1'b1;
                        if (rem_q != '0) code_q <= code_nxt;
                    end
                end
                DRAIN: begin
                    if (hit) begin
                        res_hit  <= 1'b1;
                        res_idx  <= midx_q;
                        res_chk  <= lowest_set(mask_q);
                        res_code <= mcode_q;
                    end else begin
                        res_hit  <= 1'b0;
                        res_idx  <= '0;
                        res_chk  <= '0;
                        res_code <= mcode_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
